hazard_sequencer: RTL and testbench

Pipeline hazard controller for the 5-stage core. It instantiates the load-use detector and adds EX forwarding selection, branch flush and multi-cycle data-memory wait sequencing. It then drives the per-stage stall and flush controls. It sits beside the datapath, between the ID/EX/MEM pipeline registers and the data-memory handshake, and keeps saturating hazard statistics.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/lwHazardUnit.sv | 19 +
 rtl/hazard_sequencer.sv | 178 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding, forward-select codes and the forward-priority helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwdSelect(input logic hitM, input logic hitW);
        if (hitM) begin
            return FWD_M;
        end else if (hitW) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/lwHazardUnit.sv
// Load-use detector: flags a Decode instruction that reads the register
// being loaded by the instruction currently in Execute.
module lwHazardUnit #(
    parameter int WIDTH = 5
) (
    input  logic             rst,
    input  logic [WIDTH-1:0] RegS1D,
    input  logic [WIDTH-1:0] RegS2D,
    input  logic [WIDTH-1:0] WriteRegE,
    input  logic             MeMtoRegE,
    output logic             lwstall
);

    logic srcMatch;

    assign srcMatch = (RegS1D == WriteRegE) || (RegS2D == WriteRegE);
    assign lwstall  = !rst && MeMtoRegE && srcMatch;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stall, EX forwarding, branch flush and
// data-memory wait/timeout sequencing, with saturating hazard statistics.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] RegS1D,
    input  logic [WIDTH-1:0] RegS2D,
    input  logic [WIDTH-1:0] RegS1E,
    input  logic [WIDTH-1:0] RegS2E,
    input  logic [WIDTH-1:0] WriteRegE,
    input  logic [WIDTH-1:0] WriteRegM,
    input  logic [WIDTH-1:0] WriteRegW,
    input  logic             MeMtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    localparam int               WCNT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t          state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               memTimeout_q, memTimeout_d;
    logic [CNT_W-1:0]   lwStallCnt_q, lwStallCnt_d;
    logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0]   memWaitCnt_q, memWaitCnt_d;

    logic lwstall;
    logic lws;
    logic mst;
    logic lwInc, flushInc, memInc;
    logic hitMA, hitWA, hitMB, hitWB;

    lwHazardUnit #(
        .WIDTH(WIDTH)
    ) uLwHazard (
        .rst      (!rst),
        .RegS1D   (RegS1D),
        .RegS2D   (RegS2D),
        .WriteRegE(WriteRegE),
        .MeMtoRegE(MeMtoRegE),
        .lwstall  (lwstall)
    );

    // A load targeting r0 produces nothing to wait for.
    assign lws = lwstall && (WriteRegE != '0);
    assign mst = (state_q == TIMEOUT) || (MemReqM && !MemReadyM);

    assign lwInc    = !mst && !PCSrcE && lws;
    assign flushInc = !mst && PCSrcE;
    assign memInc   = mst && (state_q != TIMEOUT);

    assign hitMA = RegWriteM && (WriteRegM != '0) && (WriteRegM == RegS1E);
    assign hitWA = RegWriteW && (WriteRegW != '0) && (WriteRegW == RegS1E);
    assign hitMB = RegWriteM && (WriteRegM != '0) && (WriteRegM == RegS2E);
    assign hitWB = RegWriteW && (WriteRegW != '0) && (WriteRegW == RegS2E);

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst) begin
            ForwardAE = fwdSelect(hitMA, hitWA);
            ForwardBE = fwdSelect(hitMB, hitWB);
            if (mst) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lws) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // wcnt counts stalled cycles spent in MEM_WAIT; TIMEOUT is left only by reset.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        memTimeout_d = memTimeout_q;
        case (state_q)
            RUN: begin
                if (mst) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MAX_WAIT)) begin
                    state_d      = TIMEOUT;
                    memTimeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            TIMEOUT: begin
                memTimeout_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        lwStallCnt_d = lwStallCnt_q;
        flushCnt_d   = flushCnt_q;
        memWaitCnt_d = memWaitCnt_q;
        if (lwInc && (lwStallCnt_q != CNT_MAX)) begin
            lwStallCnt_d = lwStallCnt_q + CNT_W'(1);
        end
        if (flushInc && (flushCnt_q != CNT_MAX)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
        if (memInc && (memWaitCnt_q != CNT_MAX)) begin
            memWaitCnt_d = memWaitCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            wcnt_q       <= '0;
            memTimeout_q <= 1'b0;
            lwStallCnt_q <= '0;
            flushCnt_q   <= '0;
            memWaitCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            memTimeout_q <= memTimeout_d;
            lwStallCnt_q <= lwStallCnt_d;
            flushCnt_q   <= flushCnt_d;
            memWaitCnt_q <= memWaitCnt_d;
        end
    end

    assign mem_timeout  = memTimeout_q;
    assign lw_stall_cnt = lwStallCnt_q;
    assign flush_cnt    = flushCnt_q;
    assign mem_wait_cnt = memWaitCnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with small counters (CNT_W=2) and a short
// memory timeout (MAX_WAIT=4) so saturation and timeout are reachable quickly.
module tb_hazard_sequencer;

    localparam int WIDTH    = 5;
    localparam int CNT_W    = 2;
    localparam int MAX_WAIT = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] RegS1D, RegS2D, RegS1E, RegS2E;
    logic [WIDTH-1:0] WriteRegE, WriteRegM, WriteRegW;
    logic             MeMtoRegE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] lw_stall_cnt, flush_cnt, mem_wait_cnt;

    int vecCount = 0;
    int errCount = 0;

    hazard_sequencer #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RegS1D      (RegS1D),
        .RegS2D      (RegS2D),
        .RegS1E      (RegS1E),
        .RegS2E      (RegS2E),
        .WriteRegE   (WriteRegE),
        .WriteRegM   (WriteRegM),
        .WriteRegW   (WriteRegW),
        .MeMtoRegE   (MeMtoRegE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .mem_timeout (mem_timeout),
        .lw_stall_cnt(lw_stall_cnt),
        .flush_cnt   (flush_cnt),
        .mem_wait_cnt(mem_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Stalls packed as {F,D,E,M}, flushes as {D,E}.
    task automatic checkCtl(input string tag, input logic [3:0] expStall, input logic [1:0] expFlush);
        checkOutput({tag, "/stall"}, int'({StallF, StallD, StallE, StallM}), int'(expStall));
        checkOutput({tag, "/flush"}, int'({FlushD, FlushE}), int'(expFlush));
    endtask

    task automatic idleInputs();
        RegS1D    = '0;
        RegS2D    = '0;
        RegS1E    = '0;
        RegS2E    = '0;
        WriteRegE = '0;
        WriteRegM = '0;
        WriteRegW = '0;
        MeMtoRegE = 1'b0;
        RegWriteM = 1'b0;
        RegWriteW = 1'b0;
        PCSrcE    = 1'b0;
        MemReqM   = 1'b0;
        MemReadyM = 1'b0;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b0;
        stepClock();
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] wrE, input logic [WIDTH-1:0] s1D,
                                 input logic [WIDTH-1:0] s2D, input logic branch);
        MeMtoRegE = 1'b1;
        WriteRegE = wrE;
        RegS1D    = s1D;
        RegS2D    = s2D;
        PCSrcE    = branch;
    endtask

    initial begin
        idleInputs();
        rst = 1'b0;
        repeat (2) stepClock();
        checkCtl("reset_idle", 4'b0000, 2'b00);
        checkOutput("reset_timeout", int'(mem_timeout), 0);
        checkOutput("reset_lwcnt", int'(lw_stall_cnt), 0);
        checkOutput("reset_memcnt", int'(mem_wait_cnt), 0);

        // Hazard conditions present while held in reset must not leak out.
        applyStimulus(5'd3, 5'd3, 5'd0, 1'b0);
        RegWriteM = 1'b1;
        WriteRegM = 5'd3;
        RegS1E    = 5'd3;
        MemReqM   = 1'b1;
        #1;
        checkCtl("reset_forced", 4'b0000, 2'b00);
        checkOutput("reset_fwdA", int'(ForwardAE), 0);
        idleInputs();
        rst = 1'b1;

        // Load-use on rs1.
        applyStimulus(5'd3, 5'd3, 5'd0, 1'b0);
        #1;
        checkCtl("lw_use", 4'b1100, 2'b01);
        stepClock();
        idleInputs();
        #1;
        checkCtl("lw_after", 4'b0000, 2'b00);
        checkOutput("lw_cnt1", int'(lw_stall_cnt), 1);

        // Load into r0 never stalls.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        checkCtl("lw_r0", 4'b0000, 2'b00);
        stepClock();
        checkOutput("lw_r0_cnt", int'(lw_stall_cnt), 1);

        // Branch overrides a simultaneous load-use.
        doReset();
        applyStimulus(5'd3, 5'd0, 5'd3, 1'b1);
        #1;
        checkCtl("br_lw", 4'b0000, 2'b11);
        stepClock();
        idleInputs();
        #1;
        checkOutput("br_flushcnt", int'(flush_cnt), 1);
        checkOutput("br_lwcnt", int'(lw_stall_cnt), 0);

        // Forwarding priority and r0 exclusion.
        RegWriteM = 1'b1;
        RegWriteW = 1'b1;
        WriteRegM = 5'd5;
        WriteRegW = 5'd5;
        RegS1E    = 5'd5;
        RegS2E    = 5'd9;
        #1;
        checkOutput("fwd_A_M", int'(ForwardAE), 2);
        checkOutput("fwd_B_none", int'(ForwardBE), 0);
        WriteRegM = 5'd0;
        #1;
        checkOutput("fwd_A_W", int'(ForwardAE), 1);
        WriteRegM = 5'd5;
        RegWriteM = 1'b0;
        RegS2E    = 5'd5;
        #1;
        checkOutput("fwd_A_noRegWriteM", int'(ForwardAE), 1);
        checkOutput("fwd_B_W", int'(ForwardBE), 1);
        RegWriteM = 1'b1;
        RegS2E    = 5'd0;
        WriteRegW = 5'd0;
        #1;
        checkOutput("fwd_B_r0", int'(ForwardBE), 0);
        checkOutput("fwd_A_M2", int'(ForwardAE), 2);
        idleInputs();

        // Three-cycle memory wait with a taken branch held behind it.
        doReset();
        MemReqM = 1'b1;
        PCSrcE  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkCtl($sformatf("memwait_%0d", i), 4'b1111, 2'b00);
            stepClock();
        end
        MemReadyM = 1'b1;
        #1;
        checkCtl("mem_release", 4'b0000, 2'b11);
        stepClock();
        idleInputs();
        #1;
        checkCtl("mem_after", 4'b0000, 2'b00);
        checkOutput("mem_waitcnt", int'(mem_wait_cnt), 3);
        checkOutput("mem_flushcnt", int'(flush_cnt), 1);
        checkOutput("mem_no_timeout", int'(mem_timeout), 0);

        // Memory never ready: one RUN cycle plus MAX_WAIT cycles in MEM_WAIT.
        doReset();
        MemReqM = 1'b1;
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            #1;
            checkCtl($sformatf("tmo_wait_%0d", i), 4'b1111, 2'b00);
            if (i == MAX_WAIT) begin
                checkOutput("tmo_not_yet", int'(mem_timeout), 0);
            end
            stepClock();
        end
        checkOutput("tmo_flag", int'(mem_timeout), 1);
        MemReqM   = 1'b0;
        MemReadyM = 1'b1;
        PCSrcE    = 1'b1;
        #1;
        checkCtl("tmo_stuck", 4'b1111, 2'b00);
        stepClock();
        checkCtl("tmo_stuck2", 4'b1111, 2'b00);
        checkOutput("tmo_memcnt_sat", int'(mem_wait_cnt), 3);
        checkOutput("tmo_flushcnt", int'(flush_cnt), 0);
        rst = 1'b0;
        #1;
        checkCtl("tmo_in_reset", 4'b0000, 2'b00);
        stepClock();
        rst = 1'b1;
        idleInputs();
        #1;
        checkCtl("tmo_recovered", 4'b0000, 2'b00);
        checkOutput("tmo_flag_clr", int'(mem_timeout), 0);
        checkOutput("tmo_memcnt_clr", int'(mem_wait_cnt), 0);

        // Five back-to-back load stalls saturate the 2-bit counter.
        applyStimulus(5'd7, 5'd0, 5'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            stepClock();
            if (i == 1) begin
                checkOutput("sat_lwcnt_2", int'(lw_stall_cnt), 2);
            end
        end
        idleInputs();
        #1;
        checkOutput("sat_lwcnt", int'(lw_stall_cnt), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
